// File: rtl/seq_alu_pkg.sv
// Shared types and defaults for the sequential ALU.
package seq_alu_pkg;

  localparam int unsigned DefaultWidth = 32;

  // Operation encoding as presented on the op bus.
  typedef enum logic [3:0] {
    OpPassA = 4'd0,
    OpPassB = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpNor   = 4'd5,
    OpNotA  = 4'd6,
    OpNotB  = 4'd7,
    OpSll   = 4'd8,
    OpSrl   = 4'd9,
    OpSra   = 4'd10,
    OpLui   = 4'd11,
    OpAdd   = 4'd12,
    OpSub   = 4'd13,
    OpMul   = 4'd14,
    OpDiv   = 4'd15
  } op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between a requester and seq_alu.
interface seq_alu_if
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             start;
  logic [3:0]       op;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             z;
  logic             n;
  logic             c;
  logic             v;
  logic             dbz;

  modport master (
    output start, op, sign, a, b,
    input  busy, done, result, result_hi, z, n, c, v, dbz
  );

  modport slave (
    input  start, op, sign, a, b,
    output busy, done, result, result_hi, z, n, c, v, dbz
  );

endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// acc_q holds the running high half (product) or partial remainder (divide);
// q_q holds the multiplier / dividend bits and collects product low bits or
// quotient bits. done_o is high during the final iteration and lo_o/hi_o/ovf_o
// carry the finished, sign-corrected values in that same cycle so the parent
// can register them on the closing edge.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             sign_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             ovf_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q;
  logic [CntW-1:0]  cnt_q;
  logic             active_q, is_div_q, sign_q, neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_sum, shifted, sub_diff;
  logic [2*WIDTH-1:0] prod, prod_f;

  // Signed operands are reduced to magnitudes; the most negative value maps
  // onto 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign mag_a = (sign_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b = (sign_i && b_i[WIDTH-1]) ? -b_i : b_i;

  assign add_sum  = {1'b0, acc_q} + {1'b0, m_q};
  assign shifted  = {acc_q, q_q[WIDTH-1]};
  assign sub_diff = shifted - {1'b0, m_q};

  // One multiply or divide step.
  always_comb begin
    acc_d = acc_q;
    q_d   = q_q;
    if (!is_div_q) begin
      if (q_q[0]) begin
        {acc_d, q_d} = {add_sum, q_q[WIDTH-1:1]};
      end else begin
        {acc_d, q_d} = {1'b0, acc_q, q_q[WIDTH-1:1]};
      end
    end else if (!sub_diff[WIDTH]) begin
      acc_d = sub_diff[WIDTH-1:0];
      q_d   = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      // A dropped shifted[WIDTH] bit always implies a successful subtract.
      acc_d = shifted[WIDTH-1:0];
      q_d   = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and overflow of the value produced by this step.
  always_comb begin
    prod   = {acc_d, q_d};
    prod_f = neg_lo_q ? -prod : prod;
    if (!is_div_q) begin
      lo_o = prod_f[WIDTH-1:0];
      hi_o = prod_f[2*WIDTH-1:WIDTH];
    end else begin
      lo_o = neg_lo_q ? -q_d : q_d;
      hi_o = neg_hi_q ? -acc_d : acc_d;
    end
    ovf_o = !is_div_q && (sign_q ? (hi_o != {WIDTH{lo_o[WIDTH-1]}}) : (hi_o != '0));
  end

  assign done_o = active_q && (cnt_q == CntW'(WIDTH - 1));

  // Operand load on start, then WIDTH iterations.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (start_i) begin
      acc_q    <= '0;
      q_q      <= mag_a;
      m_q      <= mag_b;
      cnt_q    <= '0;
      active_q <= 1'b1;
      is_div_q <= is_div_i;
      sign_q   <= sign_i;
      neg_lo_q <= sign_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      neg_hi_q <= sign_i && a_i[WIDTH-1];
    end else if (active_q) begin
      acc_q <= acc_d;
      q_q   <= q_d;
      cnt_q <= cnt_q + CntW'(1);
      if (done_o) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/shift/add ops, iterative MUL/DIV.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic   clk,
  input logic   reset,
  seq_alu_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, dbz_q, dbz_d;

  op_e              op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum, diff;
  logic             b_zero, is_div, is_md, md_start;
  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_c, alu_v, alu_dbz;
  logic             md_done, md_ovf;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign op       = op_e'(bus.op);
  assign shamt    = bus.b[SHW-1:0];
  assign sum      = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff     = {1'b0, bus.a} - {1'b0, bus.b};
  assign b_zero   = (bus.b == '0);
  assign is_div   = (op == OpDiv);
  // Divide by zero completes immediately with fixed results.
  assign is_md    = (op == OpMul) || (is_div && !b_zero);
  assign md_start = (state_q == StIdle) && bus.start && is_md;

  seq_alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk_i    (clk),
    .rst_i    (reset),
    .start_i  (md_start),
    .is_div_i (is_div),
    .sign_i   (bus.sign),
    .a_i      (bus.a),
    .b_i      (bus.b),
    .done_o   (md_done),
    .lo_o     (md_lo),
    .hi_o     (md_hi),
    .ovf_o    (md_ovf)
  );

  // Single-cycle datapath on the live request inputs.
  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_dbz = 1'b0;
    unique case (op)
      OpPassA: alu_res = bus.a;
      OpPassB: alu_res = bus.b;
      OpAnd:   alu_res = bus.a & bus.b;
      OpOr:    alu_res = bus.a | bus.b;
      OpXor:   alu_res = bus.a ^ bus.b;
      OpNor:   alu_res = ~(bus.a | bus.b);
      OpNotA:  alu_res = ~bus.a;
      OpNotB:  alu_res = ~bus.b;
      OpSll:   alu_res = bus.a << shamt;
      OpSrl:   alu_res = bus.a >> shamt;
      OpSra:   alu_res = $signed(bus.a) >>> shamt;
      OpLui:   alu_res = {bus.a[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OpAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = bus.sign && (bus.a[WIDTH-1] == bus.b[WIDTH-1])
                  && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = bus.sign && (bus.a[WIDTH-1] != bus.b[WIDTH-1])
                  && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpMul: alu_res = '0;
      OpDiv: begin
        alu_res = '1;
        alu_hi  = bus.a;
        alu_dbz = 1'b1;
      end
    endcase
  end

  // Next state and result capture.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    v_d         = v_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (is_md) begin
            state_d = StCalc;
          end else begin
            state_d     = StDone;
            result_d    = alu_res;
            result_hi_d = alu_hi;
            z_d         = (alu_res == '0);
            n_d         = alu_res[WIDTH-1];
            c_d         = alu_c;
            v_d         = alu_v;
            dbz_d       = alu_dbz;
          end
        end
      end
      StCalc: begin
        if (md_done) begin
          state_d     = StDone;
          result_d    = md_lo;
          result_hi_d = md_hi;
          z_d         = (md_lo == '0);
          n_d         = md_lo[WIDTH-1];
          c_d         = 1'b0;
          v_d         = md_ovf;
          dbz_d       = 1'b0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      result_q    <= '0;
      result_hi_q <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      v_q         <= v_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32.
module tb_seq_alu;
  import seq_alu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic [4:0]  fl;  // {z, n, c, v, dbz}
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   applied = 0;
  int   miscompares = 0;
  exp_t sb[$];

  seq_alu_if #(.WIDTH(32)) bus ();

  seq_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, " result"}, bus.result, e.res);
        chk({e.name, " result_hi"}, bus.result_hi, e.hi);
        chk({e.name, " flags zncvd"}, {bus.z, bus.n, bus.c, bus.v, bus.dbz}, e.fl);
        chk({e.name, " done cycle"}, cyc, e.done_cyc);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) chk("idle timeout", 1, 0);
  endtask

  // Called and returns at a negedge; done expected lat cycles after acceptance.
  task automatic issue(input string nm, input logic [3:0] op, input logic sg,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [31:0] eh,
                       input logic [4:0] fl, input int lat, input bit push = 1'b1);
    exp_t e;
    wait_idle();
    bus.start = 1'b1;
    bus.op    = op;
    bus.sign  = sg;
    bus.a     = a;
    bus.b     = b;
    if (push) begin
      e.name = nm; e.res = er; e.hi = eh; e.fl = fl; e.done_cyc = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int k;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.sign  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset outputs", {bus.busy, bus.done, bus.result, bus.result_hi,
                          bus.z, bus.n, bus.c, bus.v, bus.dbz}, '0);

    issue("add carry",   OpAdd, 0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 5'b10100, 1);
    issue("sub ovf",     OpSub, 1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 5'b00010, 1);
    issue("add sovf",    OpAdd, 1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 5'b01010, 1);
    issue("sub borrow",  OpSub, 0, 32'h1, 32'h2, 32'hFFFF_FFFF, 0, 5'b01100, 1);
    issue("and",   OpAnd,  0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 5'b01000, 1);
    issue("or",    OpOr,   0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 5'b01000, 1);
    issue("xor",   OpXor,  0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 5'b00000, 1);
    issue("nor",   OpNor,  0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 0, 5'b00000, 1);
    issue("passa", OpPassA, 0, 32'hF0F0_F0F0, 32'h5, 32'hF0F0_F0F0, 0, 5'b01000, 1);
    issue("passb", OpPassB, 0, 32'hF0F0_F0F0, 32'h0, 32'h0, 0, 5'b10000, 1);
    issue("nota",  OpNotA, 0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 5'b10000, 1);
    issue("notb",  OpNotB, 0, 32'h0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0, 5'b00000, 1);
    issue("sll31", OpSll,  0, 32'h1, 32'd31, 32'h8000_0000, 0, 5'b01000, 1);
    issue("sll wrapamt", OpSll, 0, 32'h1, 32'h21, 32'h2, 0, 5'b00000, 1);
    issue("srl31", OpSrl,  0, 32'h8000_0000, 32'd31, 32'h1, 0, 5'b00000, 1);
    issue("lui",   OpLui,  0, 32'h1234_ABCD, 32'h0, 32'hABCD_0000, 0, 5'b01000, 1);

    // Signed multiply with busy held for the whole operation.
    issue("mul s", OpMul, 1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 5'b01000, 33);
    bad = 0;
    k = 0;
    while (!bus.done && k < 100) begin
      if (!bus.busy) bad++;
      @(negedge clk);
      k++;
    end
    if (!bus.busy) bad++;
    chk("mul busy low cycles", bad, 0);
    chk("mul done seen", bus.done, 1'b1);

    issue("div s",  OpDiv, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5'b01000, 33);
    issue("div0",   OpDiv, 0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 5'b01001, 1);
    issue("div s2", OpDiv, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 5'b01000, 33);
    issue("div u",  OpDiv, 0, 32'd100, 32'd7, 32'd14, 32'd2, 5'b00000, 33);
    issue("mul uovf", OpMul, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 5'b10010, 33);
    issue("mul umax", OpMul, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 5'b00010, 33);

    // A start during CALC with different op/operands must be ignored.
    issue("mul held", OpMul, 0, 32'h100, 32'h300, 32'h0003_0000, 32'h0, 5'b00000, 33);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OpAdd;
    bus.a     = 32'h5555_5555;
    bus.b     = 32'h1111_1111;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Reset part-way through a divide: no done pulse, outputs cleared.
    issue("div abort", OpDiv, 0, 32'd1000, 32'd3, 32'h0, 32'h0, 5'b00000, 33, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;  // must be ignored while reset is high
    bus.op    = OpPassA;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    chk("abort outputs", {bus.busy, bus.done, bus.result, bus.result_hi,
                          bus.z, bus.n, bus.c, bus.v, bus.dbz}, '0);
    repeat (40) @(negedge clk);
    chk("abort stays idle", bus.busy, 1'b0);

    issue("sra", OpSra, 0, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'h0, 5'b01000, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; even, at least 8.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request; accepted only when busy=0.
REQ-006 SHALL have port op, input, 4 bits: operation code, sampled with start.
REQ-007 SHALL have port sign, input, 1 bit: 1=signed operands for SUB/ADD overflow, MUL, DIV; sampled with start.
REQ-008 SHALL have ports a and b, inputs, WIDTH bits each: operands, sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after acceptance through the done cycle.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse when results become valid.
REQ-011 SHALL have port result, output, WIDTH bits: primary result; MUL low half; DIV quotient.
REQ-012 SHALL have port result_hi, output, WIDTH bits: MUL high half; DIV remainder; 0 otherwise.
REQ-013 SHALL have ports z, n, c, v, outputs, 1 bit each: zero, negative, carry/borrow and overflow flags.
REQ-014 SHALL have port dbz, output, 1 bit: DIV with b=0.

Function
REQ-015 SHALL decode op: 0 PASSA, 1 PASSB, 2 AND, 3 OR, 4 XOR, 5 NOR ~(a|b), 6 NOTA, 7 NOTB, 8 SLL, 9 SRL, 10 SRA, 11 LUI, 12 ADD, 13 SUB, 14 MUL, 15 DIV.
REQ-016 SHALL take the shift amount from b[SHW-1:0]; SRA replicates a[WIDTH-1].
REQ-017 SHALL compute LUI as {a[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-018 SHALL use FSM states IDLE, CALC, DONE; IDLE->CALC on accepted start of MUL/DIV (b!=0), IDLE->DONE on any other accepted start, CALC->DONE after WIDTH iterations, DONE->IDLE unconditionally.
REQ-019 SHALL give ops 0-13 and DIV-by-zero a latency of 1: start accepted at cycle t, done=1 at t+1.
REQ-020 SHALL give MUL/DIV a latency of WIDTH+1 (shift-add multiply, restoring divide, one bit per cycle): done at t+WIDTH+1.
REQ-021 SHALL ignore start while busy=1, including the done cycle; operands are latched at acceptance, so input changes mid-operation have no effect.
REQ-022 SHALL hold result, result_hi, flags and dbz stable from the done cycle until the next done.
REQ-023 SHALL, for signed MUL/DIV, operate on magnitudes, negate the product/quotient when operand signs differ, and give the remainder the dividend's sign.
REQ-024 SHALL, for DIV with b=0, return result all-ones, result_hi=a, dbz=1, and set c=v=0.
REQ-025 SHALL set z=(result==0) and n=result[WIDTH-1] for every op.
REQ-026 SHALL set c=carry-out for ADD, c=borrow (a<b unsigned) for SUB, and c=0 otherwise.
REQ-027 SHALL set v=signed overflow for ADD/SUB when sign=1; for MUL, v=1 when result_hi is not the sign/zero extension of result; otherwise v=0.
REQ-028 SHALL wrap ADD/SUB results modulo 2^WIDTH.

Reset
REQ-029 SHALL, on reset, force IDLE and zero busy, done, result, result_hi, z, n, c, v and dbz on the next edge.
REQ-030 SHALL, on reset during CALC or DONE, abort the operation with no done pulse; a start asserted together with reset is ignored.

Structure
REQ-031 SHALL place the op encoding enum, the FSM state enum and the default WIDTH in package seq_alu_pkg.
REQ-032 SHALL implement the iterative multiply/divide datapath as sub-module seq_alu_muldiv, with its own start/done, sharing one WIDTH-bit accumulator and iteration counter.

Verification (WIDTH=32)
REQ-033 SHALL check: ADD a=0xFFFFFFFF b=1 -> result 0, z=1, c=1, v=0, done at t+1.
REQ-034 SHALL check: SUB sign=1, a=0x80000000 b=1 -> result 0x7FFFFFFF, v=1, c=0, n=0.
REQ-035 SHALL check: MUL sign=1, a=-3 b=7 -> result 0xFFFFFFEB, result_hi 0xFFFFFFFF, v=0, done exactly 33 cycles after acceptance, busy high throughout.
REQ-036 SHALL check: DIV sign=1, a=-7 b=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; a second DIV with b=0 -> result 0xFFFFFFFF, dbz=1, done at t+1.
REQ-037 SHALL check: start pulsed during MUL CALC with changed a/b/op -> ignored, original MUL result returned.
REQ-038 SHALL check: reset asserted 10 cycles into DIV -> no done, all outputs 0 next cycle; a subsequent SRA a=0x80000000 b=4 -> 0xF8000000.
